// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with a valid/ready handshake toward
// one shared resource.
//
// The grant is combinational. Once a request is offered, the choice is held
// until the resource accepts it, so idx_o stays stable under back-pressure.
// A rotating priority pointer moves past each served requester.
//
// Optional feature: define RR_LOCK_ARBITER_BURST_EN to enable burst mode.
// In burst mode, one requester may take up to MAX_BURST consecutive
// handshakes before the pointer moves past it.
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   flush_i   synchronous clear of lock, pointer and burst state; masks outputs
//   req_i     request vector, one bit per requester
//   ready_i   resource accepts the offered request this cycle
//   valid_o   a request is offered to the resource
//   idx_o     index of the offered request
//   gnt_o     one-hot handshake completion per requester
//   locked_o  offered decision is held from an earlier cycle
module rr_lock_arbiter #(
   parameter int unsigned NUM_REQ   = 8,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned IDX_W     = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               locked_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             lock_q, lock_d;
   logic [IDX_W-1:0] idx_lock_q, idx_lock_d;

   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic             hs;
   logic [IDX_W-1:0] idx_inc;

`ifdef RR_LOCK_ARBITER_BURST_EN
   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [IDX_W-1:0] last_idx_q, last_idx_d;
   logic [CNT_W-1:0] cnt_base;
`endif

   // Scan ptr_q, ptr_q+1, ... modulo NUM_REQ. The candidate never reaches
   // 2*NUM_REQ, so a single subtraction wraps it.
   always_comb begin
      int unsigned cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!sel_found && req_i[cand[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      idx_o    = lock_q ? idx_lock_q : sel_idx;
      valid_o  = (lock_q | sel_found) & ~flush_i;
      locked_o = lock_q & ~flush_i;
      hs       = valid_o & ready_i;
      gnt_o    = '0;
      if (hs) begin
         gnt_o[idx_o] = 1'b1;
      end
      // The explicit wrap keeps the pointer in range for non-power-of-two NUM_REQ.
      idx_inc = (idx_o == LAST_IDX) ? '0 : idx_o + 1'b1;
   end

   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      idx_lock_d = idx_lock_q;
`ifdef RR_LOCK_ARBITER_BURST_EN
      burst_cnt_d = burst_cnt_q;
      last_idx_d  = last_idx_q;
      cnt_base    = (idx_o == last_idx_q) ? burst_cnt_q : '0;
`endif
      if (flush_i) begin
         ptr_d      = '0;
         lock_d     = 1'b0;
         idx_lock_d = '0;
`ifdef RR_LOCK_ARBITER_BURST_EN
         burst_cnt_d = '0;
         last_idx_d  = '0;
`endif
      end else if (hs) begin
         lock_d = 1'b0;
`ifdef RR_LOCK_ARBITER_BURST_EN
         last_idx_d = idx_o;
         // Keep priority on the same requester until its burst is used up.
         if (32'(cnt_base) < MAX_BURST - 1) begin
            ptr_d       = idx_o;
            burst_cnt_d = cnt_base + 1'b1;
         end else begin
            ptr_d       = idx_inc;
            burst_cnt_d = '0;
         end
`else
         ptr_d = idx_inc;
`endif
      end else if (valid_o) begin
         lock_d     = 1'b1;
         idx_lock_d = idx_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         idx_lock_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         idx_lock_q <= idx_lock_d;
      end
   end

`ifdef RR_LOCK_ARBITER_BURST_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         burst_cnt_q <= '0;
         last_idx_q  <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
         last_idx_q  <= last_idx_d;
      end
   end
`endif

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin arbiter with a valid/ready handshake toward one shared resource (a port, bus or functional unit) used by NUM_REQ requesters.
- Grant is combinational (zero latency).
- Once offered, the decision is locked until the resource accepts it, so the selected index is stable under back-pressure.
- Fairness comes from a rotating priority pointer that moves past each served requester.

Parameters:
- NUM_REQ, 8, number of requesters; legal range is 2 or more, and non-powers of two are supported.
- MAX_BURST, 4, consecutive handshakes one requester may take before the pointer must advance; used only with the optional feature; 1 or more.
- IDX_W, $clog2(NUM_REQ), derived index width; not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of lock, pointer and burst state
- req_i  in  NUM_REQ  request vector; a requester holds its request until granted
- ready_i  in  1  resource accepts the offered request this cycle
- valid_o  out  1  a request is offered to the resource
- idx_o  out  IDX_W  index of the offered request
- gnt_o  out  NUM_REQ  one-hot handshake completion per requester
- locked_o  out  1  decision is held from a previous cycle

Behaviour:
- State registers:
  - ptr_q, IDX_W bits: highest-priority index.
  - lock_q, 1 bit.
  - idx_lock_q, IDX_W bits.
  - With the optional feature only: burst_cnt_q and last_idx_q.
  - Reset and flush value of every register is 0.
- Reset outputs (req_i=0): valid_o=0, idx_o=0, gnt_o=0, locked_o=0.
- Unlocked selection: idx_o is the first i with req_i[i]=1, scanning ptr_q, ptr_q+1, ... modulo NUM_REQ. If req_i=0, then idx_o=0 and valid_o=0; otherwise valid_o=1.
- Locked: idx_o=idx_lock_q and valid_o=1, regardless of req_i. New or higher-priority requests have no effect.
- locked_o=lock_q.
- Handshake condition: valid_o & ready_i. In that cycle gnt_o[idx_o]=1 and all other gnt_o bits are 0. gnt_o=0 in every other cycle.
- On handshake:
  - lock_q <= 0.
  - ptr_q <= idx_o+1, and wraps to 0 when idx_o=NUM_REQ-1. The explicit compare is required for non-power-of-two NUM_REQ.
- On valid_o & ~ready_i: lock_q <= 1 and idx_lock_q <= idx_o. The pointer is unchanged.
- flush_i=1 has priority over all other events:
  - In that cycle, valid_o, gnt_o and locked_o are forced to 0.
  - Next state is the reset values.
  - flush_i in the same cycle as ready_i does not produce a grant.
- Reset asserted mid-lock: all state clears immediately, and outputs take their reset values asynchronously.
- No request is dropped while locked. No requester waits more than NUM_REQ-1 handshakes, or (NUM_REQ-1)*MAX_BURST handshakes with the optional feature.

Optional Feature:
- Macro: RR_LOCK_ARBITER_BURST_EN.
- Enabled: burst mode.
  - On a handshake with idx_o == last_idx_q and burst_cnt_q < MAX_BURST-1: ptr_q <= idx_o and burst_cnt_q increments, so the same requester wins again if still requesting.
  - On a handshake with a different idx_o: count restarts at 0 before applying the same rule.
  - When the count reaches MAX_BURST-1: ptr_q <= idx_o+1 (with wrap) and burst_cnt_q <= 0.
  - last_idx_q <= idx_o on every handshake.
  - MAX_BURST=1 behaves exactly like the feature disabled.
- Disabled: no burst registers exist; MAX_BURST is ignored; the pointer always advances past the served index.

Test Plan:
1. Reset: assert rst_ni=0 with req_i=4'b1111, then release with req_i=0 -> valid_o=0, idx_o=0, gnt_o=0, locked_o=0.
2. Fairness: NUM_REQ=4, req_i=4'b1111, ready_i=1 for 5 cycles -> gnt_o sequence 0001, 0010, 0100, 1000, 0001.
3. Lock: req_i=4'b0110, ready_i=0 for 3 cycles, raise req_i[0] in cycle 2, then ready_i=1 -> idx_o=1 throughout, locked_o=1 from cycle 2, gnt_o=0010 on the accept, next idx_o=2.
4. Wrap with non-power-of-two: NUM_REQ=5, req_i=5'b10001, ready_i=1 -> idx_o alternates 0, 4, 0, 4; ptr_q never exceeds 4.
5. Flush mid-lock: locked on idx 2, then flush_i=1 together with ready_i=1 -> valid_o=0, gnt_o=0 that cycle; next cycle with req_i=4'b1111 gives idx_o=0 and locked_o=0.
6. Burst (macro defined, MAX_BURST=2, NUM_REQ=4): req_i=4'b1111, ready_i=1 -> gnt_o sequence 0001, 0001, 0010, 0010, 0100. Dropping req_i[1] after its first grant -> next grant 0100.
